// File: rtl/ltl_monitor_pkg.sv
// Shared types for the LTL monitor report path: the record stored per
// reporting symbol and the occupancy state of the record FIFO.
package ltl_monitor_pkg;

   localparam int NUM_REPORTS_DEF = 4;
   localparam int IDX_W_DEF       = 32;

   // One buffered report: the symbol index that caused it and the report vector.
   typedef struct packed {
      logic [IDX_W_DEF-1:0]       idx;
      logic [NUM_REPORTS_DEF-1:0] reports;
   } report_rec_t;

   // Occupancy state of the record FIFO.
   typedef enum logic [1:0] {
      FIFO_EMPTY   = 2'd0,
      FIFO_PARTIAL = 2'd1,
      FIFO_FULL    = 2'd2
   } fifo_state_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous record FIFO with flush. Pointers carry one extra wrap bit so
// full and empty are distinguishable; the head is read straight out of the
// storage registers and stays stable until popped. The occupancy state
// (EMPTY/PARTIAL/FULL) is exported as an FSM for the parent and checkers.
// Handshake: a push is accepted when not full, or when full and a pop happens
// in the same cycle; a pop while empty is ignored; flush wins over both.
module ltl_report_fifo
   import ltl_monitor_pkg::*;
#(
   parameter type REC_T = report_rec_t,
   parameter int  DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        push,
   input  logic        pop,
   input  REC_T        wr_rec,
   output REC_T        head,
   output fifo_state_t state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   REC_T          mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          wr_en;
   logic          rd_en;
   fifo_state_t   state_q;
   fifo_state_t   state_d;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign wr_en = push && (!full || pop) && !flush;
   assign rd_en = pop && !empty && !flush;
   assign head  = mem[rd_ptr[AW-1:0]];
   assign state = state_q;

   // Pointer update; reset and flush both return to empty.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ONE;
         if (rd_en) rd_ptr <= rd_ptr + ONE;
      end
   end

   // Record storage; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_rec;
   end

   // Occupancy state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= FIFO_EMPTY;
      else       state_q <= state_d;
   end

   // Occupancy next-state from the accepted push/pop of this cycle.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = FIFO_EMPTY;
      end else begin
         case (state_q)
            FIFO_EMPTY:   if (wr_en) state_d = FIFO_PARTIAL;
            FIFO_PARTIAL: begin
               if (wr_en && !rd_en && count == LAST) state_d = FIFO_FULL;
               else if (rd_en && !wr_en && count == ONE) state_d = FIFO_EMPTY;
            end
            FIFO_FULL:    if (rd_en && !wr_en) state_d = FIFO_PARTIAL;
            default:      state_d = FIFO_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/ltl_report_collector.sv
// Collects the report vector of one LTL automaton. Reports arrive one cycle
// after their symbol, so run and the symbol index are delayed by one cycle to
// qualify and tag them. Tagged records are buffered for a ready/valid consumer
// (rec_valid && rec_ready pops the head). Sticky seen/overflow flags and a
// saturating drop counter feed the software status block.
module ltl_report_collector
   import ltl_monitor_pkg::*;
#(
   parameter int NUM_REPORTS = NUM_REPORTS_DEF,
   parameter int IDX_W       = IDX_W_DEF,
   parameter int DEPTH       = 8,
   parameter int DROP_W      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic [NUM_REPORTS-1:0] report_in,
   input  logic                   flush,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic [IDX_W-1:0]       rec_idx,
   output logic [NUM_REPORTS-1:0] rec_reports,
   output logic [NUM_REPORTS-1:0] seen,
   output logic                   overflow,
   output logic [DROP_W-1:0]      drop_cnt
);

   typedef struct packed {
      logic [IDX_W-1:0]       idx;
      logic [NUM_REPORTS-1:0] reports;
   } rec_t;

   logic [IDX_W-1:0] sym_idx;
   logic [IDX_W-1:0] idx_d;
   logic             run_d;
   logic             push;
   logic             pop;
   logic             drop;
   rec_t             wr_rec;
   rec_t             head;
   fifo_state_t      fifo_state;

   assign push      = run_d && (|report_in);
   assign rec_valid = (fifo_state != FIFO_EMPTY);
   assign pop       = rec_valid && rec_ready;
   assign drop      = push && (fifo_state == FIFO_FULL) && !pop && !flush;
   assign wr_rec    = '{idx: idx_d, reports: report_in};
   assign rec_idx     = head.idx;
   assign rec_reports = head.reports;

   // Symbol counter and one-cycle alignment of run/index to the report.
   always_ff @(posedge clk) begin
      if (reset) begin
         sym_idx <= '0;
         idx_d   <= '0;
         run_d   <= 1'b0;
      end else begin
         run_d <= run;
         idx_d <= sym_idx;
         if (run) sym_idx <= sym_idx + IDX_W'(1);
      end
   end

   // Sticky status: seen flags, overflow and saturating drop count.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         seen     <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (run_d) seen <= seen | report_in;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end
   end

   ltl_report_fifo #(
      .REC_T (rec_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .push   (push),
      .pop    (pop),
      .wr_rec (wr_rec),
      .head   (head),
      .state  (fifo_state)
   );

endmodule
